decimal_entry_interface: RTL
============================

# decimal_entry_interface

Operator-input block for the MIPS board I/O: converts keypad decimal digit entry into a 32-bit binary word for the CPU, the reverse path of the binary-to-7-segment output interface. Pushbutton/keypad strobes are synchronised and edge-detected. Up to 8 BCD digits are shifted in and converted to binary by a sequential multiply-by-10 accumulator. The result is presented on a valid/ack handshake to the memory-mapped input port.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: stable cycles required before a key level is accepted (used only with debounce compiled in).
- NUM_DIGITS, 8: maximum digits per entry.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- KeyDigit  in  4  digit code; must be stable while KeyPress is high.
- KeyPress  in  1  raw, asynchronous, active-high digit strobe.
- KeyEnter  in  1  raw, asynchronous, active-high convert request.
- KeyClear  in  1  raw, asynchronous, active-high clear.
- EntryBcd  out  32  digits entered so far, BCD, least-significant digit in [3:0].
- DigitCount  out  4  number of digits held, 0..8.
- Overflow  out  1  sticky flag: a digit arrived while 8 were already held.
- Value  out  32  converted binary result, zero-extended.
- ValueValid  out  1  Value is ready.
- ValueAck  in  1  CPU consumed Value; synchronous, single-cycle.

## Operation
- KeyPress, KeyEnter, KeyClear and KeyDigit pass through 2-flop synchronisers. A 3rd register on each strobe produces a one-cycle rising-edge pulse.
- FSM states: ENTRY, CONVERT, DONE. Reset enters ENTRY.
- ENTRY, digit pulse:
  - Codes 10..15 are ignored.
  - If DigitCount < 8: EntryBcd <= {EntryBcd[27:0], KeyDigit} and DigitCount increments.
  - If DigitCount = 8: the digit is dropped and Overflow is set.
- ENTRY, Enter pulse: acc <= 0, index <= 7, go to CONVERT. Enter with zero digits yields Value = 0.
- CONVERT: one digit per cycle, most-significant first: acc <= acc*10 + EntryBcd[4*index+3 -: 4]. This runs for 8 cycles, then Value <= result and the FSM goes to DONE. Leading zero digits are harmless. The maximum result is 99,999,999, which fits in 27 bits.
  - acc*10 is computed as (acc<<3)+(acc<<1).
- DONE: ValueValid = 1 and Value is held stable. Digit and Enter pulses are ignored. ValueAck returns the FSM to ENTRY and clears EntryBcd, DigitCount and Overflow. Value keeps its last result.
- Clear pulse, in any state: return to ENTRY; clear EntryBcd, DigitCount, Overflow and ValueValid. Value keeps its last result.
- Same-cycle priority: Clear > Ack > Enter > digit.

## Timing
- Reset values: EntryBcd = 0, DigitCount = 0, Overflow = 0, Value = 0, ValueValid = 0, state ENTRY; all internal sync/debounce registers = 0.
- Without debounce, a strobe rising before Clk edge 0 produces its pulse after edge 2. The effect lands on edge 3.
- An Enter pulse captured on edge N gives CONVERT on edges N+1..N+8. ValueValid is high from edge N+9.
- ValueAck sampled high in DONE deasserts ValueValid on the same edge.
- Reset mid-CONVERT aborts the conversion immediately, with no partial Value update.
- Holding a strobe high produces a single pulse; it must return low before it is recognised again.

## Configuration
- KEY_DEBOUNCE_EN defined:
  - Each synchronised strobe feeds a counter. The filtered level changes only after the raw level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - The edge detector uses the filtered level.
  - Edge latency becomes 2 + DEBOUNCE_CYCLES + 1 cycles.
- Undefined: there are no counters and the edge detector uses the synchronised level directly. Use this for simulation.

## Structure
- Shared package (mips_io_pkg):
  - FSM state typedef {ENTRY, CONVERT, DONE}.
  - Constant NUM_DIGITS = 8 and BCD digit width 4.
  - Constant DIGIT_MAX = 9.
- One sub-module, key_sync_edge: 2-flop sync, optional debounce under KEY_DEBOUNCE_EN, and edge pulse. It is instantiated three times, for Press, Enter and Clear. KeyDigit uses a plain 4-bit 2-flop sync.

## Test plan
- Enter digits 1,2,3,4,5,6,7,8, then Enter: EntryBcd = 0x12345678, DigitCount = 8. ValueValid rises 9 cycles after the Enter pulse with Value = 12,345,678 (0x00BC614E).
- Enter digits 9,9,9,9,9,9,9,9,5, then Enter: the ninth digit is dropped, Overflow = 1, Value = 99,999,999 (0x05F5E0FF).
- Digit code 12, then 7, then Enter: code 12 is ignored, DigitCount = 1, Value = 7. Hold ValueValid with no ack for 20 cycles, then pulse ValueAck: ValueValid drops and DigitCount = 0.
- Enter 4,2, Enter, then Clear during cycle 3 of CONVERT: ValueValid stays 0, EntryBcd = 0, and the FSM is back in ENTRY.
- Enter with no digits gives Value = 0. Assert Reset mid-CONVERT: all outputs return to their reset values asynchronously.
- With KEY_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4, bounce KeyPress 1/0/1 over 3 cycles, then hold: exactly one digit is captured, 2+4+1 cycles after the level settles.

Source files
------------

// File: rtl/mips_io_pkg.sv
// Shared constants and FSM state encoding for the MIPS board I/O blocks.
package mips_io_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ENTRY   = 2'd0;
  localparam state_t CONVERT = 2'd1;
  localparam state_t DONE    = 2'd2;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 4;
  localparam int DIGIT_MAX  = 9;

endpackage

// File: rtl/decimal_entry_interface_key_sync_edge.sv
// Strobe conditioner: 2-flop synchroniser, optional debounce filter and registered rising-edge pulse.
// Debounce is compiled in only when KEY_DEBOUNCE_EN is defined.
module key_sync_edge #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;
  logic level;

`ifdef KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The filtered level follows the raw level only after a full run of disagreeing cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = sync2_q;
      else                                    cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  logic debounce_unused;
  assign debounce_unused = (DEBOUNCE_CYCLES != 0);
  assign level           = sync2_q;
`endif

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = level;
    pulse_d = level & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/decimal_entry_interface.sv
// Keypad decimal entry: collects up to NUM_DIGITS BCD digits and converts them to binary
// with a one-digit-per-cycle multiply-by-10 accumulator. Debounce option: KEY_DEBOUNCE_EN.
module decimal_entry_interface #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_DIGITS      = mips_io_pkg::NUM_DIGITS
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  KeyDigit,
  input  logic        KeyPress,
  input  logic        KeyEnter,
  input  logic        KeyClear,
  output logic [31:0] EntryBcd,
  output logic [3:0]  DigitCount,
  output logic        Overflow,
  output logic [31:0] Value,
  output logic        ValueValid,
  input  logic        ValueAck
);
  import mips_io_pkg::*;

  logic press_pulse, enter_pulse, clear_pulse;

  logic [BCD_W-1:0] digit_s1_q, digit_s1_d;
  logic [BCD_W-1:0] digit_s2_q, digit_s2_d;

  state_t      state_q, state_d;
  logic [31:0] entry_q, entry_d;
  logic [3:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [31:0] value_q, value_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  idx_q, idx_d;

  logic [BCD_W-1:0] cur_digit;
  logic [31:0]      acc_next;

  key_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_press (
    .clk(Clk), .rst(Reset), .raw(KeyPress), .pulse(press_pulse)
  );
  key_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(Clk), .rst(Reset), .raw(KeyEnter), .pulse(enter_pulse)
  );
  key_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(Clk), .rst(Reset), .raw(KeyClear), .pulse(clear_pulse)
  );

  assign cur_digit = entry_q[{idx_q, 2'b00} +: BCD_W];
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + 32'(cur_digit);

  always_comb begin
    digit_s1_d = KeyDigit;
    digit_s2_d = digit_s1_q;
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    value_d    = value_q;
    acc_d      = acc_q;
    idx_d      = idx_q;

    // Clear wins over everything; Value deliberately keeps the last result.
    if (clear_pulse) begin
      state_d = ENTRY;
      entry_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (enter_pulse) begin
            acc_d   = '0;
            idx_d   = 3'(NUM_DIGITS - 1);
            state_d = CONVERT;
          end else if (press_pulse && (digit_s2_q <= BCD_W'(DIGIT_MAX))) begin
            if (count_q < 4'(NUM_DIGITS)) begin
              entry_d = {entry_q[31-BCD_W:0], digit_s2_q};
              count_d = count_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        CONVERT: begin
          acc_d = acc_next;
          if (idx_q == 3'd0) begin
            value_d = acc_next;
            state_d = DONE;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
        DONE: begin
          if (ValueAck) begin
            state_d = ENTRY;
            entry_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      digit_s1_q <= '0;
      digit_s2_q <= '0;
      state_q    <= ENTRY;
      entry_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      value_q    <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
    end else begin
      digit_s1_q <= digit_s1_d;
      digit_s2_q <= digit_s2_d;
      state_q    <= state_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      value_q    <= value_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
    end
  end

  assign EntryBcd   = entry_q;
  assign DigitCount = count_q;
  assign Overflow   = ovf_q;
  assign Value      = value_q;
  assign ValueValid = (state_q == DONE);

endmodule
